// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and state type for the nibble-serial adder.
package nibble_serial_adder_pkg;

  // Width of one adder slice.
  localparam int NIB_W = 4;

  // Controller states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_adder4.sv
// 4-bit ripple adder slice with carry in and carry out.
module adder4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             i_c,
  output logic [NIB_W-1:0] sum,
  output logic             o_c
);

  // Full 5-bit sum; the top bit is the carry out of the slice.
  assign {o_c, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, i_c};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one nibble per clock through a single adder4,
// carry registered between nibbles, result published with a done pulse.
//
// state   | meaning
// ST_IDLE | waiting for start; sum/o_c hold the last completed result
// ST_RUN  | feeding one nibble per clock into adder4
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                     i_c,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     o_c
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             o_c_q, o_c_d;

  logic [NIB_W-1:0] add_sum;
  logic             add_oc;
  logic [W-1:0]     acc_shift;

  adder4 u_adder4 (
    .a   (a_sh_q[NIB_W-1:0]),
    .b   (b_sh_q[NIB_W-1:0]),
    .i_c (c_q),
    .sum (add_sum),
    .o_c (add_oc)
  );

  // New sum nibble enters at the top; shift form also covers NIBBLES=1,
  // where the accumulator contributes nothing.
  assign acc_shift = (acc_q >> NIB_W) | (W'(add_sum) << (W - NIB_W));

  // Next-state and datapath update for the serial addition.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    o_c_d   = o_c_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = i_c;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d  = acc_shift;
        c_d    = add_oc;
        a_sh_d = a_sh_q >> NIB_W;
        b_sh_d = b_sh_q >> NIB_W;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = acc_shift;
          o_c_d   = add_oc;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register all state; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      o_c_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      o_c_q   <= o_c_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign o_c  = o_c_q;

endmodule
